bc_result_acc: RTL and testbench
================================

BC_RESULT_ACC -- requirements
Module: bc_result_acc

Interface
REQ-001 Parameter NBITS, default 16: number of serial bits per incoming word, LSB first.
REQ-002 Parameter ACC_W, default 24: accumulator and result width; the block SHALL require ACC_W >= NBITS.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begins a new frame; sampled in IDLE, COLLECT and DONE.
REQ-006 num_words  input  8  words per frame; latched when start is accepted.
REQ-007 bit_vld  input  1  serial bit valid, from the bitblock column output stage.
REQ-008 bit_in  input  1  serial sum bit from the bitblock column.
REQ-009 bit_last  input  1  marks the final bit of the current word; qualified by bit_vld.
REQ-010 res  output  ACC_W  accumulated frame result.
REQ-011 res_vld  output  1  result valid.
REQ-012 res_rdy  input  1  downstream accepts the result.
REQ-013 ovf  output  1  sticky saturation flag for the current frame.
REQ-014 len_err  output  1  sticky flag: a word exceeded NBITS bits.

Function
REQ-015 The block SHALL implement the states IDLE, COLLECT and DONE.
REQ-016 IDLE + start: the block SHALL latch num_words, clear the accumulator, ovf, len_err, the bit index and the word count, then enter COLLECT (or DONE if num_words==0).
REQ-017 In COLLECT, each bit_vld beat SHALL write bit_in into the shift assembler at the current bit index and then increment the index.
REQ-018 On a beat with bit_vld && bit_last, the assembled word (including that beat's bit, upper bits zero) SHALL be added to the accumulator at that edge; the index SHALL reset to 0 and the word count SHALL increment.
REQ-019 A bit_last arriving before NBITS bits SHALL yield a word zero-extended above the received bits.
REQ-020 Beats with index >= NBITS and no bit_last SHALL be ignored, and len_err SHALL set.
REQ-021 The add SHALL be unsigned; on carry out of ACC_W the accumulator SHALL saturate to all ones and ovf SHALL set; it then stays saturated for the rest of the frame.
REQ-022 When the word count reaches the latched num_words, the block SHALL enter DONE on that same edge; res_vld SHALL be high from the next cycle.
REQ-023 In DONE, res, ovf and len_err SHALL hold stable until res_vld && res_rdy.
REQ-024 On the handshake the block SHALL return to IDLE; if start is also high in that cycle, it SHALL go directly to COLLECT with a new frame per REQ-016.
REQ-025 start in DONE without res_rdy SHALL be ignored.
REQ-026 start in COLLECT SHALL abort the frame and restart per REQ-016; partial data SHALL be discarded.
REQ-027 bit_vld in IDLE or DONE SHALL be ignored.
REQ-028 res_vld SHALL be a registered output equal to (state==DONE).

Reset
REQ-029 rst SHALL asynchronously force IDLE and clear res, res_vld, ovf, len_err, the accumulator, the assembler, the index and the word count to 0.
REQ-030 Reset asserted mid-frame or in DONE SHALL discard all frame state; no res_vld pulse SHALL follow reset release.

Structure
REQ-031 The shared package bc_pkg SHALL hold the state enum type and the NBITS/ACC_W defaults.
REQ-032 Serial-to-parallel assembly SHALL be a sub-module bc_deser (bit index, assembler, len_err detection); the FSM, saturating adder and handshake SHALL sit in bc_result_acc.

Verification
REQ-033 Basic accumulation: num_words=3, words 5, 7, 0xFFFF sent LSB first over 16 beats each -> res=0x01000B, res_vld high one cycle after the last beat, ovf=0.
REQ-034 Saturation: ACC_W=NBITS=16, num_words=2, words 0xFFFF and 0x0002 -> res=0xFFFF, ovf=1.
REQ-035 Short and long words: a word 3 with bit_last on beat 2 -> adds 3; a 20-beat word without bit_last until beat 20 -> len_err=1 and excess bits dropped.
REQ-036 Backpressure and turnaround: res_rdy low 5 cycles -> res stable; handshake with start high -> next cycle in COLLECT with res_vld=0; num_words=0 -> res=0 valid the cycle after start.
REQ-037 Abort and reset: start mid-frame -> prior words discarded; rst asserted mid-frame asynchronously -> outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared types and default sizes for the bitblock result accumulator.
// The state encoding lives here so the bench and any future blocks can decode it.
package bc_pkg;
  localparam int NBITS_DEF = 16;
  localparam int ACC_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/bc_deser.sv
// LSB-first serial-to-parallel assembler with a sticky over-length flag.
// The word is presented combinationally on the bit_last beat, including that beat's bit.
module bc_deser
  import bc_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             beat_vld,
  input  logic             bit_in,
  input  logic             bit_last,
  output logic             word_vld,
  output logic [NBITS-1:0] word,
  output logic             len_err
);
  localparam int IDX_W = $clog2(NBITS + 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NBITS);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0] asm_q, asm_d;
  logic             len_err_q, len_err_d;
  logic             in_range;
  logic [NBITS-1:0] bit_mask;

  always_comb begin
    in_range  = (idx_q < IDX_MAX);
    bit_mask  = (in_range && bit_in) ? (NBITS'(1) << idx_q) : '0;
    word      = asm_q | bit_mask;
    word_vld  = beat_vld && bit_last;
    idx_d     = idx_q;
    asm_d     = asm_q;
    len_err_d = len_err_q;
    if (clr) begin
      idx_d     = '0;
      asm_d     = '0;
      len_err_d = 1'b0;
    end else if (beat_vld) begin
      // Bits past NBITS never reach the assembler; the index parks at NBITS.
      if (!in_range) len_err_d = 1'b1;
      if (bit_last) begin
        idx_d = '0;
        asm_d = '0;
      end else begin
        asm_d = word;
        if (in_range) idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      asm_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
endmodule

// File: rtl/bc_result_acc.sv
// Frame accumulator: sums num_words deserialised words with unsigned saturation,
// then holds the result in DONE until the res_vld/res_rdy handshake.
module bc_result_acc
  import bc_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       num_words,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic             bit_last,
  output logic [ACC_W-1:0] res,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic             ovf,
  output logic             len_err
);
  if (ACC_W < NBITS) begin : g_width_check
    $error("bc_result_acc: ACC_W must be >= NBITS");
  end

  state_e           state_q, state_d;
  logic [7:0]       num_q, num_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             res_vld_q, res_vld_d;

  logic             start_acc;
  logic             beat_vld;
  logic             word_vld;
  logic [NBITS-1:0] word;
  logic [ACC_W:0]   sum;
  logic [7:0]       cnt_inc;

  // Start is honoured everywhere except DONE without a same-cycle handshake.
  assign start_acc = start && ((state_q != ST_DONE) || res_rdy);
  assign beat_vld  = bit_vld && (state_q == ST_COLLECT) && !start_acc;
  assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - NBITS){1'b0}}, word};
  assign cnt_inc   = cnt_q + 8'd1;

  bc_deser #(.NBITS(NBITS)) u_deser (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .beat_vld (beat_vld),
    .bit_in   (bit_in),
    .bit_last (bit_last),
    .word_vld (word_vld),
    .word     (word),
    .len_err  (len_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_acc) begin
      state_d = (num_words == 8'd0) ? ST_DONE : ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT: if (word_vld && (cnt_inc == num_q)) state_d = ST_DONE;
        ST_DONE:    if (res_rdy) state_d = ST_IDLE;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    num_d     = num_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    res_vld_d = (state_d == ST_DONE);
    if (start_acc) begin
      num_d = num_words;
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (word_vld) begin
      cnt_d = cnt_inc;
      // Once saturated the frame stays pinned at all ones.
      if (ovf_q || sum[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign res     = acc_q;
  assign res_vld = res_vld_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_bc_result_acc.sv
// Directed bench for bc_result_acc: a 16/24 instance plus a 16/16 instance for saturation.
module tb_bc_result_acc;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_words;
  logic        bit_vld;
  logic        bit_in;
  logic        bit_last;
  logic        res_rdy;
  logic [23:0] res;
  logic        res_vld, ovf, len_err;
  logic [15:0] s_res;
  logic        s_res_vld, s_ovf, s_len_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bc_result_acc #(.NBITS(16), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .bit_vld(bit_vld), .bit_in(bit_in), .bit_last(bit_last),
    .res(res), .res_vld(res_vld), .res_rdy(res_rdy), .ovf(ovf), .len_err(len_err)
  );

  bc_result_acc #(.NBITS(16), .ACC_W(16)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .bit_vld(bit_vld), .bit_in(bit_in), .bit_last(bit_last),
    .res(s_res), .res_vld(s_res_vld), .res_rdy(res_rdy), .ovf(s_ovf), .len_err(s_len_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] n);
    start     = 1'b1;
    num_words = n;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic beat(input logic b, input logic last);
    bit_vld  = 1'b1;
    bit_in   = b;
    bit_last = last;
    @(negedge clk);
    bit_vld  = 1'b0;
    bit_in   = 1'b0;
    bit_last = 1'b0;
  endtask

  // Beats beyond 16 carry ones so a dropped-bit bug changes the sum.
  task automatic send_word(input logic [15:0] w, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      beat((i < 16) ? w[i] : 1'b1, i == nbeats - 1);
    end
  endtask

  task automatic handshake();
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_words = 8'd0;
    bit_vld = 1'b0; bit_in = 1'b0; bit_last = 1'b0; res_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_res", 32'(res), 32'h0);
    chk("rst_vld", 32'(res_vld), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_len", 32'(len_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_vld", 32'(res_vld), 32'h0);

    // 5 + 7 + 0xFFFF = 0x1000B
    start_frame(8'd3);
    send_word(16'd5, 16);
    send_word(16'd7, 16);
    for (int i = 0; i < 15; i++) beat(1'b1, 1'b0);
    chk("basic_vld_early", 32'(res_vld), 32'h0);
    beat(1'b1, 1'b1);
    chk("basic_vld", 32'(res_vld), 32'h1);
    chk("basic_res", 32'(res), 32'h01000B);
    chk("basic_ovf", 32'(ovf), 32'h0);
    chk("basic_len", 32'(len_err), 32'h0);
    chk("basic_s_res", 32'(s_res), 32'hFFFF);
    chk("basic_s_ovf", 32'(s_ovf), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res", 32'(res), 32'h01000B);
      chk("bp_vld", 32'(res_vld), 32'h1);
    end
    handshake();
    chk("hs_vld", 32'(res_vld), 32'h0);

    // 0xFFFF + 2: saturates at 16 bits, 0x10001 at 24 bits
    start_frame(8'd2);
    send_word(16'hFFFF, 16);
    send_word(16'h0002, 16);
    chk("sat_s_res", 32'(s_res), 32'hFFFF);
    chk("sat_s_ovf", 32'(s_ovf), 32'h1);
    chk("sat_s_vld", 32'(s_res_vld), 32'h1);
    chk("sat_res", 32'(res), 32'h010001);
    chk("sat_ovf", 32'(ovf), 32'h0);
    handshake();

    // short word 3 (2 beats), then a 20-beat word whose low 16 bits are 1
    start_frame(8'd2);
    send_word(16'd3, 2);
    chk("short_res", 32'(res), 32'h3);
    chk("short_len", 32'(len_err), 32'h0);
    for (int i = 0; i < 16; i++) beat(i == 0, 1'b0);
    chk("long_len_early", 32'(len_err), 32'h0);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    chk("long_len", 32'(len_err), 32'h1);
    chk("long_res", 32'(res), 32'h4);
    chk("long_vld", 32'(res_vld), 32'h1);

    // handshake with start: straight into a new frame
    res_rdy = 1'b1; start = 1'b1; num_words = 8'd1;
    @(negedge clk);
    res_rdy = 1'b0; start = 1'b0;
    chk("turn_vld", 32'(res_vld), 32'h0);
    chk("turn_len", 32'(len_err), 32'h0);
    chk("turn_res", 32'(res), 32'h0);
    send_word(16'h00AB, 16);
    chk("turn_res2", 32'(res), 32'hAB);
    chk("turn_vld2", 32'(res_vld), 32'h1);

    // start and bit beats in DONE without res_rdy are ignored
    start_frame(8'd5);
    chk("done_start_vld", 32'(res_vld), 32'h1);
    chk("done_start_res", 32'(res), 32'hAB);
    send_word(16'hFFFF, 16);
    chk("done_bits_res", 32'(res), 32'hAB);
    chk("done_bits_vld", 32'(res_vld), 32'h1);
    handshake();
    chk("done_hs_vld", 32'(res_vld), 32'h0);

    start_frame(8'd0);
    chk("zero_vld", 32'(res_vld), 32'h1);
    chk("zero_res", 32'(res), 32'h0);
    handshake();

    // abort mid-frame
    start_frame(8'd2);
    send_word(16'h1234, 16);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
    start_frame(8'd1);
    send_word(16'h0010, 16);
    chk("abort_res", 32'(res), 32'h10);
    chk("abort_vld", 32'(res_vld), 32'h1);
    handshake();

    // asynchronous reset mid-frame
    start_frame(8'd2);
    send_word(16'h00FF, 16);
    chk("pre_rst_res", 32'(res), 32'hFF);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_res", 32'(res), 32'h0);
    chk("arst_vld", 32'(res_vld), 32'h0);
    chk("arst_ovf", 32'(ovf), 32'h0);
    chk("arst_len", 32'(len_err), 32'h0);
    chk("arst_s_res", 32'(s_res), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_vld", 32'(res_vld), 32'h0);
    end
    start_frame(8'd1);
    send_word(16'h0009, 16);
    chk("post_rst_res", 32'(res), 32'h9);
    chk("post_rst_vld2", 32'(res_vld), 32'h1);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
